// File: rtl/cpu_opponent_input_gen_pkg.sv
// -----------------------------------------------------------------------------
// cpu_opponent_input_gen_pkg
// Shared definitions for the CPU opponent input generator.
//   - PLAYER_WIDTH   : sprite width in pixels, used to find the gap between
//                      the two fighters.
//   - S_IDLE..S_BLOCKSTUN : 4-bit player controller state codes, identical to
//                      the encoding used by both gameplay controllers.
//   - ai_state_t     : decision FSM encoding, also exported on ai_mode.
//   - is_free / is_opp_attack : state classification helpers.
// -----------------------------------------------------------------------------
package cpu_opponent_input_gen_pkg;

    localparam int PLAYER_WIDTH = 64;

    localparam logic [3:0] S_IDLE             = 4'd0;
    localparam logic [3:0] S_FORWARD          = 4'd1;
    localparam logic [3:0] S_BACKWARD         = 4'd2;
    localparam logic [3:0] S_IATTACK_START    = 4'd3;
    localparam logic [3:0] S_IATTACK_ACTIVE   = 4'd4;
    localparam logic [3:0] S_IATTACK_RECOVERY = 4'd5;
    localparam logic [3:0] S_DATTACK_START    = 4'd6;
    localparam logic [3:0] S_DATTACK_ACTIVE   = 4'd7;
    localparam logic [3:0] S_DATTACK_RECOVERY = 4'd8;
    localparam logic [3:0] S_HITSTUN          = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN        = 4'd10;

    typedef enum logic [2:0] {
        S_THINK    = 3'd0,
        S_APPROACH = 3'd1,
        S_RETREAT  = 3'd2,
        S_BLOCK    = 3'd3,
        S_ATTACK   = 3'd4,
        S_ACK      = 3'd5,
        S_RECOVER  = 3'd6
    } ai_state_t;

    // A player can take new directional/attack input only while idle or walking.
    function automatic logic is_free(input logic [3:0] st);
        return (st == S_IDLE) || (st == S_FORWARD) || (st == S_BACKWARD);
    endfunction

    // Start-up and active frames of either attack are the ones worth blocking.
    function automatic logic is_opp_attack(input logic [3:0] st);
        return (st == S_IATTACK_START) || (st == S_IATTACK_ACTIVE) ||
               (st == S_DATTACK_START) || (st == S_DATTACK_ACTIVE);
    endfunction

endpackage

// File: rtl/cpu_opponent_input_gen_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (maximal length,
// so a nonzero seed never reaches the all-zero lock-up state).
// Ports:
//   clk_60Hz : frame clock
//   reset    : synchronous active-high, loads SEED
//   q[7:0]   : current LFSR value, advances every frame
// -----------------------------------------------------------------------------
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_60Hz,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    // Taps 8,6,5,4 map to bits 7,5,4,3 of the left-shifting register.
    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign q    = r_q;

    // Shift register: seeded in reset, otherwise advances once per frame.
    always_ff @(posedge clk_60Hz) begin
        if (reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule

// File: rtl/cpu_opponent_input_gen.sv
// -----------------------------------------------------------------------------
// cpu_opponent_input_gen
// Computer-controlled input source for the player-2 slot. Watches both
// fighters and, after a jittered reaction delay, chooses to approach, retreat,
// block or attack, driving the same lines a human pad would.
// Ports:
//   clk_60Hz   : frame clock shared with the gameplay controllers
//   reset      : synchronous active-high reset
//   enable     : CPU control active; 0 forces all outputs low
//   self_pos_x : P2 x position (left edge), px
//   self_state : P2 controller state
//   opp_pos_x  : P1 x position (left edge), px
//   opp_state  : P1 controller state
//   in_left    : registered forward press for P2
//   in_right   : registered backward/block press for P2
//   attack     : registered attack press (single-frame pulse)
//   ai_mode    : current decision FSM state, debug only
// -----------------------------------------------------------------------------
module cpu_opponent_input_gen
    import cpu_opponent_input_gen_pkg::*;
#(
    parameter int         ATTACK_RANGE = 20,
    parameter int         THREAT_RANGE = 40,
    parameter int         REACT_FRAMES = 6,
    parameter int         MOVE_FRAMES  = 10,
    parameter int         BLOCK_FRAMES = 18,
    parameter int         ACK_TIMEOUT  = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk_60Hz,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] self_pos_x,
    input  logic [3:0] self_state,
    input  logic [9:0] opp_pos_x,
    input  logic [3:0] opp_state,
    output logic       in_left,
    output logic       in_right,
    output logic       attack,
    output logic [2:0] ai_mode
);

    localparam logic [10:0] L_ATTACK_RANGE = 11'(ATTACK_RANGE);
    localparam logic [10:0] L_THREAT_RANGE = 11'(THREAT_RANGE);
    localparam logic [10:0] L_PLAYER_WIDTH = 11'(PLAYER_WIDTH);
    localparam logic [7:0]  L_REACT        = 8'(REACT_FRAMES);
    localparam logic [7:0]  L_MOVE_LAST    = 8'(MOVE_FRAMES - 1);
    localparam logic [7:0]  L_BLOCK_LAST   = 8'(BLOCK_FRAMES - 1);
    localparam logic [7:0]  L_ACK_LAST     = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0]  L_RESET_CNT    = 8'(REACT_FRAMES) + {6'd0, LFSR_SEED[1:0]};

    logic [7:0]  w_lfsr;
    logic        w_unused_lfsr_hi;
    logic [10:0] w_self_x;
    logic [10:0] w_opp_right;
    logic [10:0] w_gap;
    logic        w_self_free;
    logic        w_threat;
    logic [7:0]  w_jitter_cnt;

    ai_state_t   r_state;
    ai_state_t   w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        r_in_left;
    logic        r_in_right;
    logic        r_attack;
    logic        w_in_left_next;
    logic        w_in_right_next;
    logic        w_attack_next;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_60Hz (clk_60Hz),
        .reset    (reset),
        .q        (w_lfsr)
    );

    // Only the low nibble drives decisions; the upper bits just feed the shift.
    assign w_unused_lfsr_hi = ^w_lfsr[7:4];

    // Gap between P1's right edge and P2's left edge, clamped at 0 on overlap.
    assign w_self_x     = {1'b0, self_pos_x};
    assign w_opp_right  = {1'b0, opp_pos_x} + L_PLAYER_WIDTH;
    assign w_gap        = (w_self_x < w_opp_right) ? 11'd0 : (w_self_x - w_opp_right);

    assign w_self_free  = is_free(self_state);
    assign w_threat     = is_opp_attack(opp_state) && (w_gap <= L_THREAT_RANGE);

    // Reaction delay reloaded whenever the FSM returns to thinking.
    assign w_jitter_cnt = L_REACT + {6'd0, w_lfsr[1:0]};

    assign in_left  = r_in_left;
    assign in_right = r_in_right;
    assign attack   = r_attack;
    assign ai_mode  = r_state;

    // Next-state, counter and output-press decode for the decision FSM.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_in_left_next  = 1'b0;
        w_in_right_next = 1'b0;
        w_attack_next   = 1'b0;

        if (!enable) begin
            w_state_next = S_THINK;
            w_cnt_next   = w_jitter_cnt;
        end else begin
            case (r_state)
                S_THINK: begin
                    if (r_cnt != 8'd0) begin
                        w_cnt_next = r_cnt - 8'd1;
                    end else if (!w_self_free) begin
                        // Busy: keep the delay spent and re-evaluate next frame.
                        w_state_next = S_THINK;
                        w_cnt_next   = 8'd0;
                    end else if (w_threat) begin
                        w_state_next    = S_BLOCK;
                        w_in_right_next = 1'b1;
                        w_cnt_next      = L_BLOCK_LAST;
                    end else if (w_gap <= L_ATTACK_RANGE) begin
                        w_state_next   = S_ATTACK;
                        w_attack_next  = 1'b1;
                        w_in_left_next = w_lfsr[0];
                    end else if (w_lfsr[3:0] == 4'd0) begin
                        w_state_next    = S_RETREAT;
                        w_in_right_next = 1'b1;
                        w_cnt_next      = L_MOVE_LAST;
                    end else begin
                        w_state_next   = S_APPROACH;
                        w_in_left_next = 1'b1;
                        w_cnt_next     = L_MOVE_LAST;
                    end
                end
                S_APPROACH: begin
                    if ((w_gap <= L_ATTACK_RANGE) || (r_cnt == 8'd0) || !w_self_free) begin
                        w_state_next = S_THINK;
                        w_cnt_next   = w_jitter_cnt;
                    end else begin
                        w_in_left_next = 1'b1;
                        w_cnt_next     = r_cnt - 8'd1;
                    end
                end
                S_RETREAT: begin
                    if ((r_cnt == 8'd0) || !w_self_free) begin
                        w_state_next = S_THINK;
                        w_cnt_next   = w_jitter_cnt;
                    end else begin
                        w_in_right_next = 1'b1;
                        w_cnt_next      = r_cnt - 8'd1;
                    end
                end
                S_BLOCK: begin
                    if ((self_state == S_HITSTUN) || (self_state == S_BLOCKSTUN)) begin
                        w_state_next = S_RECOVER;
                    end else if (r_cnt == 8'd0) begin
                        w_state_next = S_THINK;
                        w_cnt_next   = w_jitter_cnt;
                    end else begin
                        w_in_right_next = 1'b1;
                        w_cnt_next      = r_cnt - 8'd1;
                    end
                end
                S_ATTACK: begin
                    // Press lasts one frame; then watch for the controller to react.
                    w_state_next = S_ACK;
                    w_cnt_next   = L_ACK_LAST;
                end
                S_ACK: begin
                    if (!w_self_free) begin
                        w_state_next = S_RECOVER;
                    end else if (r_cnt == 8'd0) begin
                        w_state_next = S_THINK;
                        w_cnt_next   = w_jitter_cnt;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (self_state == S_IDLE) begin
                        w_state_next = S_THINK;
                        w_cnt_next   = w_jitter_cnt;
                    end else begin
                        w_state_next = S_RECOVER;
                    end
                end
                default: begin
                    w_state_next = S_THINK;
                    w_cnt_next   = w_jitter_cnt;
                end
            endcase
        end
    end

    // State, reaction counter and registered pad outputs.
    always_ff @(posedge clk_60Hz) begin
        if (reset) begin
            r_state    <= S_THINK;
            r_cnt      <= L_RESET_CNT;
            r_in_left  <= 1'b0;
            r_in_right <= 1'b0;
            r_attack   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_in_left  <= w_in_left_next;
            r_in_right <= w_in_right_next;
            r_attack   <= w_attack_next;
        end
    end

endmodule

// File: tb/tb_cpu_opponent_input_gen.sv
// -----------------------------------------------------------------------------
// tb_cpu_opponent_input_gen
// Self-checking bench: a frame-level behavioural model predicts the pad
// outputs, ai_mode and LFSR every frame; directed scenarios add literal
// expectations for latency, pulse widths and reset/enable behaviour, then a
// long randomised run stresses the invariants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_opponent_input_gen;
    import cpu_opponent_input_gen_pkg::*;

    localparam int M_THINK    = int'(S_THINK);
    localparam int M_APPROACH = int'(S_APPROACH);
    localparam int M_RETREAT  = int'(S_RETREAT);
    localparam int M_BLOCK    = int'(S_BLOCK);
    localparam int M_ATTACK   = int'(S_ATTACK);
    localparam int M_ACK      = int'(S_ACK);
    localparam int M_RECOVER  = int'(S_RECOVER);

    logic       clk_60Hz   = 1'b0;
    logic       reset      = 1'b1;
    logic       enable     = 1'b0;
    logic [9:0] self_pos_x = 10'd0;
    logic [3:0] self_state = 4'd0;
    logic [9:0] opp_pos_x  = 10'd0;
    logic [3:0] opp_state  = 4'd0;
    logic       in_left;
    logic       in_right;
    logic       attack;
    logic [2:0] ai_mode;

    int errors = 0;
    int checks = 0;

    // Model state
    int         m_mode  = 0;
    int         m_timer = 0;
    logic       m_l     = 1'b0;
    logic       m_r     = 1'b0;
    logic       m_a     = 1'b0;
    logic [7:0] m_lfsr  = 8'h00;
    bit         m_valid = 1'b0;

    always #5 clk_60Hz = ~clk_60Hz;

    cpu_opponent_input_gen dut (
        .clk_60Hz   (clk_60Hz),
        .reset      (reset),
        .enable     (enable),
        .self_pos_x (self_pos_x),
        .self_state (self_state),
        .opp_pos_x  (opp_pos_x),
        .opp_state  (opp_state),
        .in_left    (in_left),
        .in_right   (in_right),
        .attack     (attack),
        .ai_mode    (ai_mode)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        // feedback = parity of tap bits (x^8, x^6, x^5, x^4)
        return {v[6:0], ^(v & 8'b1011_1000)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_sig(input string name, input int which, input int bound, output int n);
        logic s;
        n = 0;
        s = 1'b0;
        while (!s && n < bound) begin
            @(negedge clk_60Hz);
            n++;
            case (which)
                0:       s = in_left;
                1:       s = in_right;
                default: s = attack;
            endcase
        end
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL %s: no rise within %0d frames, required a rise", name, bound);
        end
    endtask

    task automatic model_step();
        logic [7:0] cur;
        int d, gap, jit;
        bit free, thr;
        cur = m_lfsr;
        if (reset) begin
            m_valid = 1'b1;
            m_lfsr  = 8'hA5;
            m_mode  = M_THINK;
            m_timer = 6 + 1;          // 6 + (8'hA5 & 3)
            m_l = 1'b0; m_r = 1'b0; m_a = 1'b0;
            return;
        end
        if (!m_valid) return;
        m_lfsr = lfsr_next(cur);
        d    = int'(self_pos_x) - int'(opp_pos_x) - 64;
        gap  = (d < 0) ? 0 : d;
        free = (self_state <= 4'd2);
        thr  = (opp_state == 4'd3 || opp_state == 4'd4 || opp_state == 4'd6 ||
                opp_state == 4'd7) && (gap <= 40);
        jit  = 6 + int'(cur[1:0]);
        m_l = 1'b0; m_r = 1'b0; m_a = 1'b0;
        if (!enable) begin
            m_mode  = M_THINK;
            m_timer = jit;
        end else if (m_mode == M_THINK) begin
            if (m_timer > 0)            m_timer--;
            else if (!free)             m_timer = 0;
            else if (thr)               begin m_mode = M_BLOCK;    m_r = 1'b1; m_timer = 17; end
            else if (gap <= 20)         begin m_mode = M_ATTACK;   m_a = 1'b1; m_l = cur[0]; end
            else if (cur[3:0] == 4'd0)  begin m_mode = M_RETREAT;  m_r = 1'b1; m_timer = 9; end
            else                        begin m_mode = M_APPROACH; m_l = 1'b1; m_timer = 9; end
        end else if (m_mode == M_APPROACH || m_mode == M_RETREAT) begin
            if ((m_mode == M_APPROACH && gap <= 20) || m_timer == 0 || !free) begin
                m_mode = M_THINK; m_timer = jit;
            end else begin
                m_timer--;
                if (m_mode == M_APPROACH) m_l = 1'b1; else m_r = 1'b1;
            end
        end else if (m_mode == M_BLOCK) begin
            if (self_state == 4'd9 || self_state == 4'd10) m_mode = M_RECOVER;
            else if (m_timer == 0) begin m_mode = M_THINK; m_timer = jit; end
            else begin m_r = 1'b1; m_timer--; end
        end else if (m_mode == M_ATTACK) begin
            m_mode = M_ACK; m_timer = 3;
        end else if (m_mode == M_ACK) begin
            if (!free) m_mode = M_RECOVER;
            else if (m_timer == 0) begin m_mode = M_THINK; m_timer = jit; end
            else m_timer--;
        end else begin
            if (self_state == 4'd0) begin m_mode = M_THINK; m_timer = jit; end
        end
    endtask

    // Model advances on the same edge the DUT samples.
    initial begin
        forever begin
            @(posedge clk_60Hz);
            model_step();
        end
    end

    // Per-frame comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_60Hz);
            if (m_valid) begin
                checks++;
                if ({ai_mode, in_left, in_right, attack} !== {3'(m_mode), m_l, m_r, m_a}) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t: got mode/l/r/a=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                             $time, ai_mode, in_left, in_right, attack, m_mode, m_l, m_r, m_a);
                end
                checks++;
                if (in_left && in_right) begin
                    errors++;
                    $display("FAIL lr_exclusive t=%0t: got both high, required not both", $time);
                end
                checks++;
                if (dut.u_lfsr.q !== m_lfsr || dut.u_lfsr.q == 8'h00) begin
                    errors++;
                    $display("FAIL lfsr_cmp t=%0t: got %0h expected %0h (nonzero)", $time, dut.u_lfsr.q, m_lfsr);
                end
            end
        end
    end

    initial begin
        int n, h, hits, acks, extra;

        // 1: reset state, LFSR pins, first approach latency and hold length
        enable = 1'b1; self_pos_x = 10'd567; opp_pos_x = 10'd64;
        self_state = 4'd0; opp_state = 4'd0;
        repeat (3) @(negedge clk_60Hz);
        chk("reset_outputs", {29'd0, in_left, in_right, attack}, 32'd0);
        chk("reset_mode", {29'd0, ai_mode}, M_THINK);
        chk("reset_lfsr", {24'd0, dut.u_lfsr.q}, 32'hA5);
        reset = 1'b0;
        @(negedge clk_60Hz);
        chk("lfsr_step1", {24'd0, dut.u_lfsr.q}, 32'h4A);
        @(negedge clk_60Hz);
        chk("lfsr_step2", {24'd0, dut.u_lfsr.q}, 32'h95);
        wait_sig("approach_rise", 0, 20, n);
        chk("approach_latency", n + 2, 8);
        h = 0;
        while (in_left == 1'b1 && h < 30) begin
            h++;
            @(negedge clk_60Hz);
        end
        chk("approach_hold", h, 10);

        // 2: busy self blocks all action, then attack on the next decision
        self_state = 4'd4; self_pos_x = 10'd138; opp_pos_x = 10'd64;
        hits = 0;
        repeat (20) begin
            @(negedge clk_60Hz);
            if (in_left || in_right || attack) hits++;
        end
        chk("busy_quiet", hits, 0);
        self_state = 4'd0;
        wait_sig("attack_after_busy", 2, 5, n);
        chk("attack_after_busy_latency", n, 1);
        @(negedge clk_60Hz);
        chk("attack_width", {31'd0, attack}, 0);
        chk("attack_to_ack", {29'd0, ai_mode}, M_ACK);

        // 3: opponent attack in threat range -> block, blockstun -> recover
        self_pos_x = 10'd158; opp_state = 4'd3;
        wait_sig("block_rise", 1, 30, n);
        chk("block_mode", {29'd0, ai_mode}, M_BLOCK);
        repeat (3) @(negedge clk_60Hz);
        chk("block_held", {31'd0, in_right}, 1);
        self_state = 4'd10;
        @(negedge clk_60Hz);
        chk("blockstun_release", {31'd0, in_right}, 0);
        chk("blockstun_recover", {29'd0, ai_mode}, M_RECOVER);
        self_state = 4'd0;
        @(negedge clk_60Hz);
        chk("recover_to_think", {29'd0, ai_mode}, M_THINK);

        // 4: unacknowledged attack -> 4 frames of ACK, no second press
        opp_state = 4'd0; self_pos_x = 10'd133;
        wait_sig("ack_attack", 2, 30, n);
        acks = 0; extra = 0;
        repeat (6) begin
            @(negedge clk_60Hz);
            if (ai_mode == 3'(M_ACK)) acks++;
            if (attack) extra++;
        end
        chk("ack_frames", acks, 4);
        chk("ack_no_repress", extra, 0);
        chk("ack_exit", {29'd0, ai_mode}, M_THINK);

        // 5: reset mid-approach, then enable drop mid-block
        self_pos_x = 10'd567;
        wait_sig("approach_rise2", 0, 40, n);
        reset = 1'b1;
        @(negedge clk_60Hz);
        chk("reset_mid_left", {31'd0, in_left}, 0);
        chk("reset_mid_lfsr", {24'd0, dut.u_lfsr.q}, 32'hA5);
        chk("reset_mid_mode", {29'd0, ai_mode}, M_THINK);
        reset = 1'b0;
        self_pos_x = 10'd158; opp_state = 4'd3;
        wait_sig("block_rise2", 1, 40, n);
        enable = 1'b0;
        @(negedge clk_60Hz);
        chk("disable_outputs", {29'd0, in_left, in_right, attack}, 0);
        chk("disable_mode", {29'd0, ai_mode}, M_THINK);
        enable = 1'b1;

        // 6: overlapping sprites clamp the gap to 0 and choose attack
        opp_state = 4'd0; self_pos_x = 10'd100; opp_pos_x = 10'd80;
        wait_sig("overlap_attack", 2, 30, n);

        // Random run: model compare plus invariants every frame
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_60Hz);
            if ($urandom_range(7, 0) == 0) begin
                opp_pos_x  = 10'($urandom_range(600, 0));
                self_pos_x = ($urandom_range(3, 0) == 0) ? 10'($urandom_range(1023, 0))
                                                         : 10'(int'(opp_pos_x) + 40 + int'($urandom_range(80, 0)));
            end
            if ($urandom_range(3, 0) == 0)
                self_state = ($urandom_range(9, 0) < 6) ? 4'($urandom_range(2, 0)) : 4'($urandom_range(10, 3));
            if ($urandom_range(5, 0) == 0) opp_state = 4'($urandom_range(10, 0));
            enable = ($urandom_range(49, 0) != 0);
            reset  = ($urandom_range(399, 0) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_60Hz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
